// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-back data cache controller.
package dcache_pkg;

  localparam int DEF_WAYS           = 2;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int MAX_WAYS           = 8;

  typedef enum logic [2:0] {
    READY      = 3'd0,
    WRITEBACK  = 3'd1,
    FILL       = 3'd2,
    CACHEWRITE = 3'd3,
    FINISH     = 3'd4
  } dcache_state_t;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [MAX_WAYS-1:0] onehot_lowest(input logic [MAX_WAYS-1:0] v);
    return v & (~v + MAX_WAYS'(1));
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Victim way selection: lowest invalid way first, otherwise a round-robin pointer
// that advances only when a pointer-chosen line has been installed.
module dcache_victim_sel
  import dcache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [WAYS-1:0] line_valid_i,
  input  logic            advance_i,
  output logic [WAYS-1:0] victim_o,
  output logic            from_ptr_o
);

  localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [PW-1:0]       ptr_q, ptr_d;
  logic [MAX_WAYS-1:0] invalid_ext, lowest_inv;

  assign invalid_ext = MAX_WAYS'(~line_valid_i);
  assign lowest_inv  = onehot_lowest(invalid_ext);
  assign from_ptr_o  = &line_valid_i;
  assign victim_o    = from_ptr_o ? (WAYS'(1) << ptr_q) : lowest_inv[WAYS-1:0];

  // With a single way the wrap test is always true, so the pointer stays 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = (32'(ptr_q) == WAYS - 1) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dcache_ctrl_wb.sv
// N-way data cache controller with burst refill. Define DCACHE_WRITEBACK_EN for
// write-back/write-allocate; otherwise stores write through and never allocate.
module dcache_ctrl_wb
  import dcache_pkg::*;
#(
  parameter  int WAYS           = DEF_WAYS,
  parameter  int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  localparam int BW             = $clog2(WORDS_PER_LINE)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            re_i,
  input  logic            we_i,
  input  logic            hit_i,
  input  logic [WAYS-1:0] hit_way_i,
  input  logic [WAYS-1:0] line_valid_i,
  input  logic [WAYS-1:0] line_dirty_i,
  input  logic            mem_valid_i,
  output logic            stall_o,
  output logic [WAYS-1:0] way_sel_o,
  output logic            data_we_o,
  output logic            tag_we_o,
  output logic            set_dirty_o,
  output logic            clr_dirty_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic [BW-1:0]   beat_o
);

  dcache_state_t   state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [WAYS-1:0] victim_q, victim_d, victim_w;
  logic            from_ptr_q, from_ptr_d, from_ptr_w;
  logic            advance, store, load, last_beat;

  assign store     = we_i;
  assign load      = re_i & ~we_i;
  assign last_beat = (beat_q == BW'(WORDS_PER_LINE - 1));
  assign beat_o    = beat_q;

  dcache_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .line_valid_i (line_valid_i),
    .advance_i    (advance),
    .victim_o     (victim_w),
    .from_ptr_o   (from_ptr_w)
  );

`ifdef DCACHE_WRITEBACK_EN
  logic victim_dirty;
  assign victim_dirty = |(victim_w & line_valid_i & line_dirty_i);
`else
  logic unused_dirty;
  assign unused_dirty = ^line_dirty_i;
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    victim_d    = victim_q;
    from_ptr_d  = from_ptr_q;
    advance     = 1'b0;
    stall_o     = 1'b0;
    way_sel_o   = '0;
    data_we_o   = 1'b0;
    tag_we_o    = 1'b0;
    set_dirty_o = 1'b0;
    clr_dirty_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    case (state_q)
      READY: begin
`ifdef DCACHE_WRITEBACK_EN
        if (load || store) begin
          if (hit_i) begin
            way_sel_o   = hit_way_i;
            data_we_o   = store;
            set_dirty_o = store;
          end else begin
            stall_o    = 1'b1;
            victim_d   = victim_w;
            from_ptr_d = from_ptr_w;
            state_d    = victim_dirty ? WRITEBACK : FILL;
          end
        end
`else
        // Write-through store holds the pipeline until memory takes the word.
        if (store) begin
          stall_o     = 1'b1;
          mem_write_o = 1'b1;
          data_we_o   = hit_i;
          way_sel_o   = hit_i ? hit_way_i : '0;
          if (mem_valid_i) state_d = FINISH;
        end else if (load) begin
          if (hit_i) begin
            way_sel_o = hit_way_i;
          end else begin
            stall_o    = 1'b1;
            victim_d   = victim_w;
            from_ptr_d = from_ptr_w;
            state_d    = FILL;
          end
        end
`endif
      end
`ifdef DCACHE_WRITEBACK_EN
      WRITEBACK: begin
        stall_o     = 1'b1;
        mem_write_o = 1'b1;
        way_sel_o   = victim_q;
        if (mem_valid_i) begin
          if (last_beat) begin
            clr_dirty_o = 1'b1;
            beat_d      = '0;
            state_d     = FILL;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
`endif
      FILL: begin
        stall_o    = 1'b1;
        mem_read_o = 1'b1;
        way_sel_o  = victim_q;
        if (mem_valid_i) begin
          data_we_o = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = CACHEWRITE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      CACHEWRITE: begin
        stall_o   = 1'b1;
        tag_we_o  = 1'b1;
        way_sel_o = victim_q;
        advance   = from_ptr_q;
        state_d   = FINISH;
      end
      FINISH:  state_d = READY;
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= READY;
      beat_q     <= '0;
      victim_q   <= '0;
      from_ptr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      victim_q   <= victim_d;
      from_ptr_q <= from_ptr_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_wb.sv
// Directed bench for dcache_ctrl_wb (WAYS=2, WORDS_PER_LINE=4); write-back scenarios
// run when DCACHE_WRITEBACK_EN is defined, write-through scenarios otherwise.
module tb_dcache_ctrl_wb;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       re_i, we_i, hit_i, mem_valid_i;
  logic [1:0] hit_way_i, line_valid_i, line_dirty_i;
  logic       stall_o, data_we_o, tag_we_o, set_dirty_o, clr_dirty_o, mem_read_o, mem_write_o;
  logic [1:0] way_sel_o, beat_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // {stall, way_sel[1:0], data_we, tag_we, set_dirty, clr_dirty, mem_read, mem_write, beat[1:0]}
  logic [10:0] obs;
  assign obs = {stall_o, way_sel_o, data_we_o, tag_we_o, set_dirty_o, clr_dirty_o,
                mem_read_o, mem_write_o, beat_o};

  dcache_ctrl_wb #(.WAYS(2), .WORDS_PER_LINE(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .re_i         (re_i),
    .we_i         (we_i),
    .hit_i        (hit_i),
    .hit_way_i    (hit_way_i),
    .line_valid_i (line_valid_i),
    .line_dirty_i (line_dirty_i),
    .mem_valid_i  (mem_valid_i),
    .stall_o      (stall_o),
    .way_sel_o    (way_sel_o),
    .data_we_o    (data_we_o),
    .tag_we_o     (tag_we_o),
    .set_dirty_o  (set_dirty_o),
    .clr_dirty_o  (clr_dirty_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .beat_o       (beat_o)
  );

  always #5 clk_i = ~clk_i;

  // Input vector: {re, we, hit, hit_way[1:0], line_valid[1:0], line_dirty[1:0], mem_valid}
  task automatic drive(input logic [9:0] v);
    {re_i, we_i, hit_i, hit_way_i, line_valid_i, line_dirty_i, mem_valid_i} = v;
  endtask

  task automatic test_reset();
    drive(10'b0);
    reset_i = 1'b1;
    #2;
    total_cnt++;
    if (obs !== 11'b0) $display("FAIL reset_held: got %b want %b", obs, 11'b0);
    else begin pass_cnt++; $display("ok   reset_held out=%b", obs); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    #2;
    total_cnt++;
    if (obs !== 11'b0) $display("FAIL reset_release: got %b want %b", obs, 11'b0);
    else begin pass_cnt++; $display("ok   reset_release out=%b", obs); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_load_hit();
    logic [9:0]  vi [2];
    logic [10:0] ve [2];
    vi[0] = 10'b1_0_1_10_11_00_0; ve[0] = 11'b0_10_0_0_0_0_0_0_00;
    vi[1] = 10'b0_0_0_00_11_00_0; ve[1] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 2; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL load_hit[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   load_hit[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

  // Invalid way1 chosen, zero-wait refill, 6 stall cycles.
  task automatic test_clean_miss();
    logic [9:0]  vi [8];
    logic [10:0] ve [8];
    for (int i = 0; i < 6; i++) vi[i] = 10'b1_0_0_00_01_00_1;
    vi[6] = 10'b1_0_1_10_11_00_0;
    vi[7] = 10'b0_0_0_00_11_00_0;
    ve[0] = 11'b1_00_0_0_0_0_0_0_00;
    ve[1] = 11'b1_10_1_0_0_0_1_0_00;
    ve[2] = 11'b1_10_1_0_0_0_1_0_01;
    ve[3] = 11'b1_10_1_0_0_0_1_0_10;
    ve[4] = 11'b1_10_1_0_0_0_1_0_11;
    ve[5] = 11'b1_10_0_1_0_0_0_0_00;
    ve[6] = 11'b0_00_0_0_0_0_0_0_00;
    ve[7] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 8; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL clean_miss[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   clean_miss[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

  // Both ways valid: pointer picks way0 then way1, advancing after each install.
  task automatic test_round_robin();
    logic [9:0]  vi [14];
    logic [10:0] ve [14];
    for (int m = 0; m < 2; m++) begin
      vi[m*7] = 10'b1_0_0_00_11_00_0;
      for (int b = 1; b < 6; b++) vi[m*7+b] = 10'b1_0_0_00_11_00_1;
      ve[m*7] = 11'b1_00_0_0_0_0_0_0_00;
      ve[m*7+6] = 11'b0;
    end
    vi[6]  = 10'b1_0_1_01_11_00_0;
    vi[13] = 10'b1_0_1_10_11_00_0;
    ve[1] = 11'b1_01_1_0_0_0_1_0_00;  ve[8]  = 11'b1_10_1_0_0_0_1_0_00;
    ve[2] = 11'b1_01_1_0_0_0_1_0_01;  ve[9]  = 11'b1_10_1_0_0_0_1_0_01;
    ve[3] = 11'b1_01_1_0_0_0_1_0_10;  ve[10] = 11'b1_10_1_0_0_0_1_0_10;
    ve[4] = 11'b1_01_1_0_0_0_1_0_11;  ve[11] = 11'b1_10_1_0_0_0_1_0_11;
    ve[5] = 11'b1_01_0_1_0_0_0_0_00;  ve[12] = 11'b1_10_0_1_0_0_0_0_00;
    for (int i = 0; i < 14; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL round_robin[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   round_robin[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

  // mem_valid every other cycle: beat holds in gaps, 10 stall cycles total.
  task automatic test_gap_fill();
    logic [9:0]  vi [11];
    logic [10:0] ve [11];
    vi[0] = 10'b1_0_0_00_10_00_0;
    for (int i = 1; i < 9; i++) vi[i] = {9'b1_0_0_00_10_00, 1'(i % 2 == 0)};
    vi[9]  = 10'b1_0_0_00_10_00_0;
    vi[10] = 10'b1_0_1_01_11_00_0;
    ve[0]  = 11'b1_00_0_0_0_0_0_0_00;
    ve[1]  = 11'b1_01_0_0_0_0_1_0_00;
    ve[2]  = 11'b1_01_1_0_0_0_1_0_00;
    ve[3]  = 11'b1_01_0_0_0_0_1_0_01;
    ve[4]  = 11'b1_01_1_0_0_0_1_0_01;
    ve[5]  = 11'b1_01_0_0_0_0_1_0_10;
    ve[6]  = 11'b1_01_1_0_0_0_1_0_10;
    ve[7]  = 11'b1_01_0_0_0_0_1_0_11;
    ve[8]  = 11'b1_01_1_0_0_0_1_0_11;
    ve[9]  = 11'b1_01_0_1_0_0_0_0_00;
    ve[10] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 11; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL gap_fill[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   gap_fill[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

`ifdef DCACHE_WRITEBACK_EN
  task automatic test_store_hit();
    logic [9:0]  vi [2];
    logic [10:0] ve [2];
    vi[0] = 10'b0_1_1_10_11_00_0; ve[0] = 11'b0_10_1_0_1_0_0_0_00;
    vi[1] = 10'b0_0_0_00_11_10_0; ve[1] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 2; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL store_hit_wb[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   store_hit_wb[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

  // Dirty way0 written back, refilled, pointer 0->1; next miss evicts way1.
  task automatic test_writeback();
    logic [9:0]  vi [18];
    logic [10:0] ve [18];
    vi[0] = 10'b1_0_0_00_11_01_0;
    for (int i = 1; i < 10; i++) vi[i] = 10'b1_0_0_00_11_01_1;
    vi[10] = 10'b1_0_1_01_11_00_0;
    vi[11] = 10'b1_0_0_00_11_00_0;
    for (int i = 12; i < 17; i++) vi[i] = 10'b1_0_0_00_11_00_1;
    vi[17] = 10'b1_0_1_10_11_00_0;
    ve[0]  = 11'b1_00_0_0_0_0_0_0_00;
    ve[1]  = 11'b1_01_0_0_0_0_0_1_00;
    ve[2]  = 11'b1_01_0_0_0_0_0_1_01;
    ve[3]  = 11'b1_01_0_0_0_0_0_1_10;
    ve[4]  = 11'b1_01_0_0_0_1_0_1_11;
    ve[5]  = 11'b1_01_1_0_0_0_1_0_00;
    ve[6]  = 11'b1_01_1_0_0_0_1_0_01;
    ve[7]  = 11'b1_01_1_0_0_0_1_0_10;
    ve[8]  = 11'b1_01_1_0_0_0_1_0_11;
    ve[9]  = 11'b1_01_0_1_0_0_0_0_00;
    ve[10] = 11'b0_00_0_0_0_0_0_0_00;
    ve[11] = 11'b1_00_0_0_0_0_0_0_00;
    ve[12] = 11'b1_10_1_0_0_0_1_0_00;
    ve[13] = 11'b1_10_1_0_0_0_1_0_01;
    ve[14] = 11'b1_10_1_0_0_0_1_0_10;
    ve[15] = 11'b1_10_1_0_0_0_1_0_11;
    ve[16] = 11'b1_10_0_1_0_0_0_0_00;
    ve[17] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 18; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL writeback[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   writeback[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

  // re&we miss allocates invalid way1 (no writeback despite way0 dirty); replay sets dirty.
  task automatic test_store_miss();
    logic [9:0]  vi [9];
    logic [10:0] ve [9];
    vi[0] = 10'b1_1_0_00_01_01_0;
    for (int i = 1; i < 6; i++) vi[i] = 10'b1_1_0_00_01_01_1;
    vi[6] = 10'b1_1_1_10_11_01_0;
    vi[7] = 10'b1_1_1_10_11_01_0;
    vi[8] = 10'b0_0_0_00_11_11_0;
    ve[0] = 11'b1_00_0_0_0_0_0_0_00;
    ve[1] = 11'b1_10_1_0_0_0_1_0_00;
    ve[2] = 11'b1_10_1_0_0_0_1_0_01;
    ve[3] = 11'b1_10_1_0_0_0_1_0_10;
    ve[4] = 11'b1_10_1_0_0_0_1_0_11;
    ve[5] = 11'b1_10_0_1_0_0_0_0_00;
    ve[6] = 11'b0_00_0_0_0_0_0_0_00;
    ve[7] = 11'b0_10_1_0_1_0_0_0_00;
    ve[8] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 9; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL store_miss_wb[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   store_miss_wb[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask
`else
  task automatic test_store_hit();
    logic [9:0]  vi [4];
    logic [10:0] ve [4];
    vi[0] = 10'b0_1_1_10_11_00_0; ve[0] = 11'b1_10_1_0_0_0_0_1_00;
    vi[1] = 10'b0_1_1_10_11_00_1; ve[1] = 11'b1_10_1_0_0_0_0_1_00;
    vi[2] = 10'b0_1_1_10_11_00_0; ve[2] = 11'b0_00_0_0_0_0_0_0_00;
    vi[3] = 10'b0_0_0_00_11_00_0; ve[3] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 4; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL store_hit_wt[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   store_hit_wt[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

  // Store miss: single-word write, mem_valid on the third cycle, no allocation.
  task automatic test_store_miss();
    logic [9:0]  vi [5];
    logic [10:0] ve [5];
    vi[0] = 10'b1_1_0_00_11_00_0; ve[0] = 11'b1_00_0_0_0_0_0_1_00;
    vi[1] = 10'b1_1_0_00_11_00_0; ve[1] = 11'b1_00_0_0_0_0_0_1_00;
    vi[2] = 10'b1_1_0_00_11_00_1; ve[2] = 11'b1_00_0_0_0_0_0_1_00;
    vi[3] = 10'b1_1_0_00_11_00_0; ve[3] = 11'b0_00_0_0_0_0_0_0_00;
    vi[4] = 10'b0_0_0_00_11_00_0; ve[4] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 5; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL store_miss_wt[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   store_miss_wt[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask

  // Dirty bits are ignored: a load miss on dirty lines goes straight to refill.
  task automatic test_writeback();
    logic [9:0]  vi [7];
    logic [10:0] ve [7];
    vi[0] = 10'b1_0_0_00_11_11_0;
    for (int i = 1; i < 6; i++) vi[i] = 10'b1_0_0_00_11_11_1;
    vi[6] = 10'b1_0_1_01_11_11_0;
    ve[0] = 11'b1_00_0_0_0_0_0_0_00;
    ve[1] = 11'b1_01_1_0_0_0_1_0_00;
    ve[2] = 11'b1_01_1_0_0_0_1_0_01;
    ve[3] = 11'b1_01_1_0_0_0_1_0_10;
    ve[4] = 11'b1_01_1_0_0_0_1_0_11;
    ve[5] = 11'b1_01_0_1_0_0_0_0_00;
    ve[6] = 11'b0_00_0_0_0_0_0_0_00;
    for (int i = 0; i < 7; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL no_writeback_wt[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   no_writeback_wt[%0d] out=%b", i, obs); end
      @(posedge clk_i); #1;
    end
  endtask
`endif

  // Async reset at FILL beat 2 aborts the burst; a new miss restarts at beat 0.
  task automatic test_reset_mid_fill();
    logic [9:0]  vi [4];
    logic [10:0] ve [4];
    vi[0] = 10'b1_0_0_00_01_00_0; ve[0] = 11'b1_00_0_0_0_0_0_0_00;
    vi[1] = 10'b1_0_0_00_01_00_1; ve[1] = 11'b1_10_1_0_0_0_1_0_00;
    vi[2] = 10'b1_0_0_00_01_00_1; ve[2] = 11'b1_10_1_0_0_0_1_0_01;
    vi[3] = 10'b1_0_0_00_01_00_0; ve[3] = 11'b1_10_0_0_0_0_1_0_10;
    for (int i = 0; i < 4; i++) begin
      drive(vi[i]); #2;
      total_cnt++;
      if (obs !== ve[i]) $display("FAIL reset_mid_fill[%0d]: got %b want %b", i, obs, ve[i]);
      else begin pass_cnt++; $display("ok   reset_mid_fill[%0d] out=%b", i, obs); end
      if (i < 3) begin @(posedge clk_i); #1; end
    end
    drive(10'b0);
    reset_i = 1'b1;
    #2;
    total_cnt++;
    if (obs !== 11'b0) $display("FAIL reset_mid_fill_abort: got %b want %b", obs, 11'b0);
    else begin pass_cnt++; $display("ok   reset_mid_fill_abort out=%b", obs); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    #2;
    total_cnt++;
    if (obs !== 11'b0) $display("FAIL reset_mid_fill_idle: got %b want %b", obs, 11'b0);
    else begin pass_cnt++; $display("ok   reset_mid_fill_idle out=%b", obs); end
    @(posedge clk_i); #1;
    drive(10'b1_0_0_00_01_00_0); #2;
    total_cnt++;
    if (obs !== 11'b1_00_0_0_0_0_0_0_00) $display("FAIL reset_mid_fill_remiss: got %b want %b", obs, 11'b1_00_0_0_0_0_0_0_00);
    else begin pass_cnt++; $display("ok   reset_mid_fill_remiss out=%b", obs); end
    @(posedge clk_i); #1;
    drive(10'b1_0_0_00_01_00_1); #2;
    total_cnt++;
    if (obs !== 11'b1_10_1_0_0_0_1_0_00) $display("FAIL reset_mid_fill_beat0: got %b want %b", obs, 11'b1_10_1_0_0_0_1_0_00);
    else begin pass_cnt++; $display("ok   reset_mid_fill_beat0 out=%b", obs); end
    drive(10'b0);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(10'b0);
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    test_load_hit();
    test_clean_miss();
    test_round_robin();
    test_gap_fill();
    test_store_hit();
    test_writeback();
    test_store_miss();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl_wb.md
# dcache_ctrl_wb

Parametrised write-back, write-allocate data cache controller for the LEG memory stage. It is the successor to the single-way write-through controller. The FSM supports N-way set associativity and multi-word lines, and refills a line as a beat-by-beat memory burst. Dirty victims are written back before the refill, and victims are chosen from invalid ways first, then round-robin. It sits between the datapath (stall, re/we) and the tag/data arrays plus the memory bus interface.

## Interface
- WAYS, 2: associativity, 1..8
- WORDS_PER_LINE, 4: beats per line, power of 2, 2..16
- BW, $clog2(WORDS_PER_LINE): beat index width (derived, not overridden)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- re  in  1  load request this cycle
- we  in  1  store request this cycle (re&we treated as store)
- hit  in  1  tag match in selected set
- hit_way  in  WAYS  one-hot matching way (valid only when hit)
- line_valid  in  WAYS  valid bits of selected set
- line_dirty  in  WAYS  dirty bits of selected set
- mem_valid  in  1  memory beat accepted/returned this cycle
- stall  out  1  freeze pipeline
- way_sel  out  WAYS  one-hot way addressed by arrays
- data_we  out  1  write one word into data array
- tag_we  out  1  write tag, set valid
- set_dirty  out  1  set dirty bit of way_sel
- clr_dirty  out  1  clear dirty bit of way_sel
- mem_read  out  1  refill burst in progress
- mem_write  out  1  writeback burst in progress
- beat  out  BW  word index of current burst beat

## Operation
- States: READY, WRITEBACK, FILL, CACHEWRITE, FINISH.
- READY, no request: stay; outputs low.
- READY, load hit: stay, no stall; way_sel=hit_way.
- READY, store hit: stay, no stall; data_we=1, set_dirty=1, way_sel=hit_way.
- READY, miss (re|we, ~hit): latch victim; stall=1.
  - Victim is the lowest-index invalid way if any line_valid bit is 0, else the round-robin pointer.
  - Go to WRITEBACK if the victim is valid and dirty, else to FILL.
- WRITEBACK: mem_write=1, way_sel=victim. Each mem_valid increments beat. After the beat=WORDS_PER_LINE-1 accept: clr_dirty=1, beat←0, go to FILL.
- FILL: mem_read=1, way_sel=victim. Each mem_valid: data_we=1 and beat increments. After the last beat: go to CACHEWRITE.
- CACHEWRITE: tag_we=1; round-robin pointer advances (mod WAYS) only if the victim came from the pointer; go to FINISH.
- FINISH: stall=0; always go to READY. The datapath replays the access, which now hits. A store replay sets dirty via the READY store-hit path.
- mem_valid is ignored in READY, CACHEWRITE and FINISH.
- WAYS=1: the victim is always way 0 and the pointer is constant 0.

## Timing
- Reset (async): state=READY, beat=0, pointer=0, victim=0. All outputs 0 except way_sel=0.
- Reset mid-burst aborts immediately with no cleanup; the line remains whatever the arrays hold.
- stall is combinational and asserted in:
  - READY on a miss;
  - WRITEBACK;
  - FILL;
  - CACHEWRITE.
- Hit latency: 0 stall cycles.
- Clean miss, zero-wait memory: 1 (READY) + WORDS_PER_LINE + 1 (CACHEWRITE) stall cycles; FINISH is unstalled.
- Dirty miss adds WORDS_PER_LINE cycles.
- Each wait cycle (mem_valid=0) in a burst adds one cycle with beat held.
- beat wraps to 0 on the last accepted beat of every burst.

## Configuration
- DCACHE_WRITEBACK_EN defined: behaviour as above.
- Undefined: write-through, no write-allocate.
  - A store hit updates the array (data_we, no set_dirty) and also performs a single-word mem_write until mem_valid, with stall high until then.
  - A store miss performs only the single-word mem_write; no fill.
  - The WRITEBACK state, set_dirty and clr_dirty are removed; dirty outputs are tied to 0.

## Structure
- dcache_pkg holds:
  - the dcache_state_t enum (logic [2:0]);
  - a onehot_lowest(vector) function;
  - default parameter constants.
- Sub-module dcache_victim_sel holds the invalid-first priority, the round-robin pointer register and its advance input. It outputs the one-hot victim.

## Test plan
- WAYS=2, WPL=4: load miss with line_valid=2'b01, mem_valid every cycle.
  - Required: victim=way1; FILL beats 0..3 with data_we each; tag_we in the following cycle; stall for exactly 6 cycles.
- Store hit, hit_way=2'b10: data_we=1, set_dirty=1, way_sel=2'b10 in the same cycle, stall=0.
- Both ways valid, victim way0 dirty: 4 WRITEBACK beats with mem_write, clr_dirty on the last beat, then 4 FILL beats. Pointer goes 0→1 after CACHEWRITE.
- Miss with mem_valid asserted every other cycle: beat holds during each gap; total stall = 2+2×4 cycles.
- Assert reset during FILL at beat=2: the next cycle has state READY, beat=0, stall=0 and mem_read=0.
- DCACHE_WRITEBACK_EN undefined, store miss, mem_valid after 3 cycles: mem_write high for 3 cycles, no data_we, stall released next cycle.
